// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: bundles the psum receiver's data and handshake signals.
//   in          : col packed psums, lane i at in[bw_psum*i +: bw_psum]
//   wr          : per-lane push strobes
//   rd          : pop one aligned row
//   out         : registered popped row, same lane packing as in
//   o_valid     : every lane holds data, so a row can be popped
//   o_rd_valid  : out was loaded by a pop on the previous edge
//   o_full      : at least one lane is full
//   o_ready     : no lane is full
//   o_overflow  : sticky, a push was dropped
//   o_underflow : sticky, rd arrived while no row was available
// master is the side that drives pushes and pops (mac_array/writeback);
// slave is the FIFO itself.
interface psum_ofifo_if #(
    parameter int col     = 8,
    parameter int bw_psum = 22
);
    logic [col*bw_psum-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [col*bw_psum-1:0] out;
    logic                   o_valid;
    logic                   o_rd_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_rd_valid, o_full, o_ready, o_overflow, o_underflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_rd_valid, o_full, o_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: output-side receiver for the MAC column array.
// Every column pushes into its own circular lane FIFO, so columns can arrive
// with diagonal skew. A reader pops one aligned row, taking the head of every
// lane, once all lanes hold data.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : psum_ofifo_if slave (in/wr/rd in, out/status flags out)
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 64
)(
    input  logic         clk,
    input  logic         reset,
    psum_ofifo_if.slave  bus
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = 1;

    logic [bw_psum-1:0]     mem [col][depth];
    logic [aw:0]            wr_ptr [col];
    logic [aw:0]            rd_ptr [col];
    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         push_ok;
    logic                   row_valid;
    logic                   pop_ok;
    logic [col*bw_psum-1:0] out_q;
    logic                   rd_valid_q;
    logic                   overflow_q;
    logic                   underflow_q;

    // The pointer MSB is the wrap bit: equal addresses mean empty when the
    // wrap bits match and full when they differ.
    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        for (int i = 0; i < col; i++) begin
            lane_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            lane_full[i]  = (wr_ptr[i][aw-1:0] == rd_ptr[i][aw-1:0]) &&
                            (wr_ptr[i][aw] != rd_ptr[i][aw]);
        end
    end

    // Full is judged on pre-edge pointers, so a push into a full lane is
    // dropped even when the same edge pops a row.
    assign push_ok   = bus.wr & ~lane_full;
    assign row_valid = &(~lane_empty);
    assign pop_ok    = bus.rd & row_valid;

    // Storage has no reset; only the pointers define what is queued.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (reset && push_ok[i]) begin
                mem[i][wr_ptr[i][aw-1:0]] <= bus.in[i*bw_psum +: bw_psum];
            end
        end
    end

    // A pop reads the head before the pointer advances; because a lane is
    // never full and empty at once, a same-edge push cannot hit the head slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            out_q       <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + ptr_one;
                end
                if (pop_ok) begin
                    rd_ptr[i] <= rd_ptr[i] + ptr_one;
                    out_q[i*bw_psum +: bw_psum] <= mem[i][rd_ptr[i][aw-1:0]];
                end
            end
            rd_valid_q <= pop_ok;
            if (|(bus.wr & lane_full)) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd && !row_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_valid     = row_valid;
    assign bus.o_full      = |lane_full;
    assign bus.o_ready     = ~|lane_full;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed self-checking bench for psum_ofifo.
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, so every check sees the state produced by the preceding edge.
module tb_psum_ofifo;
    localparam int COL   = 8;
    localparam int BW    = 22;
    localparam int DEPTH = 64;
    localparam int W     = COL*BW;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    psum_ofifo_if #(.col(COL), .bw_psum(BW)) bus ();

    psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane i of the returned row holds base + stride*i.
    function automatic logic [W-1:0] make_row(input int base, input int stride);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            r[i*BW +: BW] = BW'(base + stride*i);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_o_valid: got %b expected 0", bus.o_valid);
        end
        checks++;
        if (bus.o_full !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_full_ready: got full=%b ready=%b expected full=0 ready=1",
                     bus.o_full, bus.o_ready);
        end
        checks++;
        if (bus.out !== '0 || bus.o_rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out: got out=%h rd_valid=%b expected out=0 rd_valid=0",
                     bus.out, bus.o_rd_valid);
        end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got ovf=%b unf=%b expected 0 0",
                     bus.o_overflow, bus.o_underflow);
        end
    endtask

    // Lane i pushes 100*i+k at cycle i+k; a row exists once lane 7 has pushed.
    task automatic test_skewed_fill();
        logic [W-1:0]   v;
        logic [COL-1:0] w;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            v = '0;
            w = '0;
            for (int i = 0; i < COL; i++) begin
                if (c >= i && c < i + 4) begin
                    w[i] = 1'b1;
                    v[i*BW +: BW] = BW'(100*i + c - i);
                end
            end
            bus.wr = w;
            bus.in = v;
            tick();
            checks++;
            if (bus.o_valid !== (c >= 7)) begin
                failures++;
                $display("[TB] FAIL skew_o_valid_c%0d: got %b expected %b", c, bus.o_valid, (c >= 7));
            end
        end
        bus.wr = '0;
        for (int k = 0; k < 4; k++) begin
            bus.rd = 1'b1;
            tick();
            checks++;
            if (bus.o_rd_valid !== 1'b1 || bus.out !== make_row(k, 100)) begin
                failures++;
                $display("[TB] FAIL skew_row%0d: got rd_valid=%b out=%h expected 1 %h",
                         k, bus.o_rd_valid, bus.out, make_row(k, 100));
            end
            checks++;
            if (bus.o_valid !== (k < 3)) begin
                failures++;
                $display("[TB] FAIL skew_valid_after_pop%0d: got %b expected %b", k, bus.o_valid, (k < 3));
            end
        end
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.out !== make_row(3, 100)) begin
            failures++;
            $display("[TB] FAIL skew_idle_hold: got rd_valid=%b out=%h expected 0 %h",
                     bus.o_rd_valid, bus.out, make_row(3, 100));
        end
    endtask

    // Fill lane 3, push once more, then give the other lanes one entry each
    // and pop: lane 3 must still return its first value.
    task automatic test_full_overflow();
        logic [W-1:0] v;
        do_reset();
        bus.wr = 8'b0000_1000;
        for (int k = 0; k < DEPTH; k++) begin
            v = '0;
            v[3*BW +: BW] = BW'(k + 1);
            bus.in = v;
            tick();
            if (k == DEPTH - 2) begin
                checks++;
                if (bus.o_full !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL full_at_63: got %b expected 0", bus.o_full);
                end
            end
        end
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_at_64: got full=%b ready=%b valid=%b expected 1 0 0",
                     bus.o_full, bus.o_ready, bus.o_valid);
        end
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_before: got %b expected 0", bus.o_overflow);
        end
        v = '0;
        v[3*BW +: BW] = BW'(12'hABC);
        bus.in = v;
        tick();
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_full !== 1'b1 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_after: got ovf=%b full=%b valid=%b expected 1 1 0",
                     bus.o_overflow, bus.o_full, bus.o_valid);
        end
        bus.wr = 8'b1111_0111;
        bus.in = make_row(50, 1);
        tick();
        bus.wr = '0;
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_lane3_kept: got valid=%b full=%b expected 1 1",
                     bus.o_valid, bus.o_full);
        end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        v = make_row(50, 1);
        v[3*BW +: BW] = BW'(1);
        checks++;
        if (bus.out !== v || bus.o_full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_pop_row: got out=%h full=%b expected %h 0", bus.out, bus.o_full, v);
        end
    endtask

    // Lane i pushes 8*c+i at cycle c; pops start one cycle later so each
    // popped row is the previous cycle's push.
    task automatic test_wrap();
        do_reset();
        bus.wr = '1;
        bus.in = make_row(0, 1);
        tick();
        for (int c = 1; c < 200; c++) begin
            bus.in = make_row(8*c, 1);
            bus.rd = 1'b1;
            tick();
            checks++;
            if (bus.o_rd_valid !== 1'b1 || bus.out !== make_row(8*(c-1), 1)) begin
                failures++;
                $display("[TB] FAIL wrap_c%0d: got rd_valid=%b out=%h expected 1 %h",
                         c, bus.o_rd_valid, bus.out, make_row(8*(c-1), 1));
            end
        end
        bus.wr = '0;
        tick();
        bus.rd = 1'b0;
        checks++;
        if (bus.out !== make_row(8*199, 1) || bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_last: got out=%h valid=%b expected %h 0",
                     bus.out, bus.o_valid, make_row(8*199, 1));
        end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_flags: got ovf=%b unf=%b expected 0 0",
                     bus.o_overflow, bus.o_underflow);
        end
    endtask

    // Lane 0 holds 63 entries; push+pop keeps it at 63, so one more push
    // is exactly what makes it full.
    task automatic test_simul_push_pop();
        logic [W-1:0] v;
        do_reset();
        for (int k = 0; k < DEPTH - 1; k++) begin
            bus.wr = (k == 0) ? 8'hFF : 8'h01;
            v = make_row(2000, 1);
            v[0 +: BW] = BW'(1000 + k);
            bus.in = v;
            tick();
        end
        checks++;
        if (bus.o_full !== 1'b0 || bus.o_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sim_pre: got full=%b valid=%b expected 0 1", bus.o_full, bus.o_valid);
        end
        bus.wr = 8'h01;
        bus.in = make_row(5555, 0);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        v = make_row(2000, 1);
        v[0 +: BW] = BW'(1000);
        checks++;
        if (bus.o_rd_valid !== 1'b1 || bus.out !== v || bus.o_full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sim_pop: got rd_valid=%b out=%h full=%b expected 1 %h 0",
                     bus.o_rd_valid, bus.out, bus.o_full, v);
        end
        bus.in = make_row(5556, 0);
        tick();
        bus.wr = '0;
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sim_occupancy: got full=%b ovf=%b expected 1 0", bus.o_full, bus.o_overflow);
        end
    endtask

    // Pop row A, queue row B on every lane but 5, try to pop, then complete
    // lane 5 and pop B.
    task automatic test_underflow();
        do_reset();
        bus.wr = '1;
        bus.in = make_row(300, 1);
        tick();
        bus.wr = '0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        bus.wr = 8'b1101_1111;
        bus.in = make_row(400, 1);
        tick();
        bus.wr = '0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        checks++;
        if (bus.o_underflow !== 1'b1 || bus.o_rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unf_flag: got unf=%b rd_valid=%b expected 1 0", bus.o_underflow, bus.o_rd_valid);
        end
        checks++;
        if (bus.out !== make_row(300, 1)) begin
            failures++;
            $display("[TB] FAIL unf_out_hold: got %h expected %h", bus.out, make_row(300, 1));
        end
        bus.wr = 8'b0010_0000;
        bus.in = make_row(400, 1);
        tick();
        bus.wr = '0;
        checks++;
        if (bus.o_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unf_valid_after_fill: got %b expected 1", bus.o_valid);
        end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        checks++;
        if (bus.o_rd_valid !== 1'b1 || bus.out !== make_row(400, 1) || bus.o_underflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unf_later_pop: got rd_valid=%b out=%h unf=%b expected 1 %h 1",
                     bus.o_rd_valid, bus.out, bus.o_underflow, make_row(400, 1));
        end
    endtask

    // Reset lands while rows are queued and both rd and wr are active; it
    // must win and discard everything. Runs straight after test_underflow,
    // so out and o_underflow are non-zero going in.
    task automatic test_reset_mid();
        bus.wr = '1;
        for (int k = 0; k < 10; k++) begin
            bus.in = make_row(600 + 8*k, 1);
            tick();
        end
        reset  = 1'b0;
        bus.rd = 1'b1;
        bus.in = make_row(3000, 1);
        tick();
        reset  = 1'b1;
        bus.rd = 1'b0;
        bus.wr = '0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.out !== '0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_state: got valid=%b out=%h ready=%b expected 0 0 1",
                     bus.o_valid, bus.out, bus.o_ready);
        end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0 || bus.o_rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_flags: got ovf=%b unf=%b rd_valid=%b expected 0 0 0",
                     bus.o_overflow, bus.o_underflow, bus.o_rd_valid);
        end
        bus.wr = '1;
        bus.in = make_row(777, 1);
        tick();
        bus.wr = '0;
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        checks++;
        if (bus.o_rd_valid !== 1'b1 || bus.out !== make_row(777, 1) || bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_new_row: got rd_valid=%b out=%h valid=%b expected 1 %h 0",
                     bus.o_rd_valid, bus.out, bus.o_valid, make_row(777, 1));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.wr   = '0;
        bus.rd   = 1'b0;
        bus.in   = '0;
        test_reset();
        test_skewed_fill();
        test_full_overflow();
        test_wrap();
        test_simul_push_pop();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
